// File: rtl/divider_iter_if.sv
// Handshake and data bundle for divider_iter: operand request, cancel and result response.
// The master drives operands and consumes results; the slave is the divider.
interface divider_iter_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic             in_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             cancel;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;
   logic             busy;

   modport master (
      output in_valid, in_signed, dividend, divisor, cancel, out_ready,
      input  in_ready, out_valid, quotient, remainder, div_by_zero, busy
   );

   modport slave (
      input  in_valid, in_signed, dividend, divisor, cancel, out_ready,
      output in_ready, out_valid, quotient, remainder, div_by_zero, busy
   );
endinterface

// File: rtl/divider_iter.sv
// Multi-cycle restoring divider, one quotient bit per clock, signed or unsigned per operation.
// Divides magnitudes, then applies sign correction on the final iteration edge.
module divider_iter #(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   divider_iter_if.slave dif
);
   localparam int CNT_W = $clog2(WIDTH) + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] quot_q, quot_d;
   logic [WIDTH-1:0] rmd_q, rmd_d;
   logic             dbz_q, dbz_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             sign_a_q, sign_a_d;
   logic             sign_b_q, sign_b_d;
   logic             zero_q, zero_d;
   logic [WIDTH-1:0] a_q, a_d;      // dividend magnitude, shifted out as quotient bits shift in
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] dvd_q, dvd_d;
   logic [WIDTH:0]   rem_q, rem_d;

   logic             in_ready;
   logic             accept;
   logic             last_iter;
   logic [WIDTH:0]   shifted;
   logic [WIDTH+1:0] diff;
   logic             q_bit;
   logic [WIDTH-1:0] q_mag;
   logic [WIDTH-1:0] r_mag;
   logic [WIDTH:0]   rem_next;

   assign in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && dif.out_ready);
   assign accept    = dif.in_valid && in_ready && !dif.cancel;
   assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

   // Trial subtraction is one bit wider than the partial remainder so its MSB is the borrow.
   assign shifted  = {rem_q[WIDTH-1:0], a_q[WIDTH-1]};
   assign diff     = {1'b0, shifted} - {2'b00, b_q};
   assign q_bit    = ~diff[WIDTH+1];
   assign q_mag    = {a_q[WIDTH-2:0], q_bit};
   assign rem_next = q_bit ? diff[WIDTH:0] : shifted;
   assign r_mag    = rem_next[WIDTH-1:0];

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      out_valid_d = out_valid_q;
      quot_d      = quot_q;
      rmd_d       = rmd_q;
      dbz_d       = dbz_q;
      cnt_d       = cnt_q;
      sign_a_d    = sign_a_q;
      sign_b_d    = sign_b_q;
      zero_d      = zero_q;
      a_d         = a_q;
      b_d         = b_q;
      dvd_d       = dvd_q;
      rem_d       = rem_q;

      if (dif.cancel) begin
         state_d     = S_IDLE;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: ;
            S_BUSY: begin
               a_d   = q_mag;
               rem_d = rem_next;
               cnt_d = cnt_q + CNT_W'(1);
               if (last_iter) begin
                  state_d     = S_DONE;
                  out_valid_d = 1'b1;
                  if (zero_q) begin
                     quot_d = '1;
                     rmd_d  = dvd_q;
                     dbz_d  = 1'b1;
                  end else begin
                     quot_d = (sign_a_q ^ sign_b_q) ? -q_mag : q_mag;
                     rmd_d  = sign_a_q ? -r_mag : r_mag;
                     dbz_d  = 1'b0;
                  end
               end
            end
            S_DONE: begin
               if (dif.out_ready) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase

         // An accept in DONE overrides the return to IDLE, giving back-to-back operation.
         if (accept) begin
            sign_a_d    = dif.in_signed & dif.dividend[WIDTH-1];
            sign_b_d    = dif.in_signed & dif.divisor[WIDTH-1];
            a_d         = (dif.in_signed & dif.dividend[WIDTH-1]) ? -dif.dividend : dif.dividend;
            b_d         = (dif.in_signed & dif.divisor[WIDTH-1])  ? -dif.divisor  : dif.divisor;
            dvd_d       = dif.dividend;
            zero_d      = (dif.divisor == '0);
            rem_d       = '0;
            cnt_d       = '0;
            state_d     = S_BUSY;
            out_valid_d = 1'b0;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         out_valid_q <= 1'b0;
         quot_q      <= '0;
         rmd_q       <= '0;
         dbz_q       <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         quot_q      <= quot_d;
         rmd_q       <= rmd_d;
         dbz_q       <= dbz_d;
         cnt_q       <= cnt_d;
      end
   end

   // NOTE: datapath registers are always loaded on accept before use, so they carry no reset.
   always_ff @(posedge clk) begin
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      zero_q   <= zero_d;
      a_q      <= a_d;
      b_q      <= b_d;
      dvd_q    <= dvd_d;
      rem_q    <= rem_d;
   end

   assign dif.in_ready    = in_ready;
   assign dif.out_valid   = out_valid_q;
   assign dif.quotient    = quot_q;
   assign dif.remainder   = rmd_q;
   assign dif.div_by_zero = dbz_q;
   assign dif.busy        = (state_q == S_BUSY);
endmodule

// File: tb/tb_divider_iter.sv
// Self-checking bench for divider_iter: directed vector table, handshake/cancel/reset sequences,
// and random operations against an arithmetic reference model, at WIDTH=32 and WIDTH=8.
module tb_divider_iter;
   logic clk;
   logic reset;
   int   tests;
   int   fails;

   divider_iter_if #(.WIDTH(32)) if32 ();
   divider_iter_if #(.WIDTH(8))  if8 ();

   divider_iter #(.WIDTH(32)) u_dut32 (.clk(clk), .reset(reset), .dif(if32));
   divider_iter #(.WIDTH(8))  u_dut8  (.clk(clk), .reset(reset), .dif(if8));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] q;
      logic [31:0] r;
      bit          z;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Reference: plain integer division (truncating toward zero) plus the divide-by-zero rule.
   function automatic void model(input int w, input bit s, input logic [63:0] a,
                                 input logic [63:0] b, output logic [63:0] q,
                                 output logic [63:0] r, output bit z);
      logic [63:0] mask;
      longint      sa;
      longint      sb;
      mask = (64'd1 << w) - 64'd1;
      z    = (b == 64'd0);
      if (z) begin
         q = mask;
         r = a;
      end else if (s) begin
         sa = longint'(a) - (a[w-1] ? (longint'(1) << w) : longint'(0));
         sb = longint'(b) - (b[w-1] ? (longint'(1) << w) : longint'(0));
         q  = 64'(sa / sb) & mask;
         r  = 64'(sa % sb) & mask;
      end else begin
         q = a / b;
         r = a % b;
      end
   endfunction

   task automatic start32(input bit s, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      if32.in_valid  = 1'b1;
      if32.in_signed = s;
      if32.dividend  = a;
      if32.divisor   = b;
      @(posedge clk);
      #1;
      if32.in_valid  = 1'b0;
      if32.in_signed = 1'($urandom);
      if32.dividend  = $urandom;
      if32.divisor   = $urandom;
   endtask

   task automatic wait32(output int lat);
      lat = 0;
      while (!if32.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic consume32();
      @(negedge clk);
      if32.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if32.out_ready = 1'b0;
   endtask

   task automatic run32(input bit s, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] q, output logic [31:0] r, output bit z,
                        output int lat);
      start32(s, a, b);
      wait32(lat);
      q = if32.quotient;
      r = if32.remainder;
      z = if32.div_by_zero;
      consume32();
   endtask

   task automatic run8(input bit s, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output bit z,
                       output int lat);
      @(negedge clk);
      if8.in_valid  = 1'b1;
      if8.in_signed = s;
      if8.dividend  = a;
      if8.divisor   = b;
      @(posedge clk);
      #1;
      if8.in_valid  = 1'b0;
      if8.dividend  = 8'($urandom);
      if8.divisor   = 8'($urandom);
      lat = 0;
      while (!if8.out_valid && lat < 100) begin
         @(posedge clk);
         #1;
         lat++;
      end
      q = if8.quotient;
      r = if8.remainder;
      z = if8.div_by_zero;
      @(negedge clk);
      if8.out_ready = 1'b1;
      @(posedge clk);
      #1;
      if8.out_ready = 1'b0;
   endtask

   initial begin
      logic [31:0] q, r;
      logic [7:0]  q8, r8;
      logic [63:0] mq, mr;
      bit          z, mz, s;
      logic [31:0] a, b;
      int          lat;
      bit          seen;

      tests = 0;
      fails = 0;
      {if32.in_valid, if32.in_signed, if32.cancel, if32.out_ready} = '0;
      {if8.in_valid, if8.in_signed, if8.cancel, if8.out_ready}     = '0;
      if32.dividend = '0;
      if32.divisor  = '0;
      if8.dividend  = '0;
      if8.divisor   = '0;

      vecs[0]  = '{1'b1, 32'd7,        32'd2,        32'd3,        32'd1,        1'b0};
      vecs[1]  = '{1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      vecs[2]  = '{1'b0, 32'hFFFFFFF9, 32'd2,        32'h7FFFFFFC, 32'd1,        1'b0};
      vecs[3]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0,        1'b0};
      vecs[4]  = '{1'b1, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
      vecs[5]  = '{1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5,        1'b1};
      vecs[6]  = '{1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1};
      vecs[7]  = '{1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b0};
      vecs[8]  = '{1'b0, 32'd100,      32'd7,        32'd14,       32'd2,        1'b0};
      vecs[9]  = '{1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        1'b0};
      vecs[10] = '{1'b1, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 1'b0};

      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 64'(if32.out_valid), 64'd0);
      check("rst_busy", 64'(if32.busy), 64'd0);
      check("rst_quotient", 64'(if32.quotient), 64'd0);
      check("rst_remainder", 64'(if32.remainder), 64'd0);
      check("rst_dbz", 64'(if32.div_by_zero), 64'd0);
      check("rst_in_ready", 64'(if32.in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 11; i++) begin
         run32(vecs[i].s, vecs[i].a, vecs[i].b, q, r, z, lat);
         check($sformatf("vec%0d_q", i), 64'(q), 64'(vecs[i].q));
         check($sformatf("vec%0d_r", i), 64'(r), 64'(vecs[i].r));
         check($sformatf("vec%0d_dbz", i), 64'(z), 64'(vecs[i].z));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd32);
      end

      // Backpressure, then consume and accept a new operation on the same edge.
      start32(1'b1, 32'd1000, 32'd3);
      check("hold_busy", 64'(if32.busy), 64'd1);
      wait32(lat);
      check("hold_latency", 64'(lat), 64'd32);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check($sformatf("hold%0d_valid", i), 64'(if32.out_valid), 64'd1);
         check($sformatf("hold%0d_in_ready", i), 64'(if32.in_ready), 64'd0);
         check($sformatf("hold%0d_q", i), 64'(if32.quotient), 64'd333);
         check($sformatf("hold%0d_r", i), 64'(if32.remainder), 64'd1);
      end
      if32.out_ready = 1'b1;
      if32.in_valid  = 1'b1;
      if32.in_signed = 1'b0;
      if32.dividend  = 32'd100;
      if32.divisor   = 32'd7;
      #1;
      check("b2b_in_ready", 64'(if32.in_ready), 64'd1);
      @(posedge clk);
      #1;
      if32.in_valid  = 1'b0;
      if32.out_ready = 1'b0;
      check("b2b_consumed", 64'(if32.out_valid), 64'd0);
      check("b2b_busy", 64'(if32.busy), 64'd1);
      wait32(lat);
      check("b2b_latency", 64'(lat), 64'd32);
      check("b2b_q", 64'(if32.quotient), 64'd14);
      check("b2b_r", 64'(if32.remainder), 64'd2);
      consume32();

      // Cancel ten cycles into an operation.
      start32(1'b0, 32'd12345, 32'd67);
      repeat (9) @(posedge clk);
      @(negedge clk);
      check("cancel_pre_busy", 64'(if32.busy), 64'd1);
      if32.cancel = 1'b1;
      @(posedge clk);
      #1;
      if32.cancel = 1'b0;
      check("cancel_busy", 64'(if32.busy), 64'd0);
      check("cancel_in_ready", 64'(if32.in_ready), 64'd1);
      seen = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         seen |= if32.out_valid;
      end
      check("cancel_no_result", 64'(seen), 64'd0);
      run32(1'b0, 32'd9, 32'd3, q, r, z, lat);
      check("after_cancel_q", 64'(q), 64'd3);
      check("after_cancel_r", 64'(r), 64'd0);
      check("after_cancel_lat", 64'(lat), 64'd32);

      // Cancel blocks an accept even while in_ready is high.
      @(negedge clk);
      if32.in_valid = 1'b1;
      if32.cancel   = 1'b1;
      @(posedge clk);
      #1;
      if32.in_valid = 1'b0;
      if32.cancel   = 1'b0;
      check("cancel_blocks_accept", 64'(if32.busy), 64'd0);

      // Cancel while a result is held.
      start32(1'b0, 32'd50, 32'd5);
      wait32(lat);
      @(negedge clk);
      if32.cancel = 1'b1;
      @(posedge clk);
      #1;
      if32.cancel = 1'b0;
      check("cancel_done_valid", 64'(if32.out_valid), 64'd0);
      check("cancel_done_in_ready", 64'(if32.in_ready), 64'd1);

      // Reset mid-operation.
      start32(1'b0, 32'd12345, 32'd67);
      repeat (9) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_mid_busy", 64'(if32.busy), 64'd0);
      check("reset_mid_valid", 64'(if32.out_valid), 64'd0);
      check("reset_mid_q", 64'(if32.quotient), 64'd0);
      run32(1'b0, 32'd9, 32'd3, q, r, z, lat);
      check("after_reset_q", 64'(q), 64'd3);
      check("after_reset_r", 64'(r), 64'd0);

      // Random 32-bit operations against the model.
      for (int i = 0; i < 40; i++) begin
         s = 1'($urandom);
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = 32'd0;
            1:       b = (32'($urandom_range(1, 15)) ^ {32{1'($urandom)}});
            2:       b = $urandom;
            default: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         endcase
         run32(s, a, b, q, r, z, lat);
         model(32, s, 64'(a), 64'(b), mq, mr, mz);
         check($sformatf("rnd32_%0d_q", i), 64'(q), mq);
         check($sformatf("rnd32_%0d_r", i), 64'(r), mr);
         check($sformatf("rnd32_%0d_dbz", i), 64'(z), 64'(mz));
         check($sformatf("rnd32_%0d_lat", i), 64'(lat), 64'd32);
      end

      // WIDTH=8 instance.
      run8(1'b1, 8'h81, 8'd3, q8, r8, z, lat);
      check("w8_q", 64'(q8), 64'hD6);
      check("w8_r", 64'(r8), 64'hFF);
      check("w8_lat", 64'(lat), 64'd8);
      @(negedge clk);
      if8.in_valid  = 1'b1;
      if8.in_signed = 1'b0;
      if8.dividend  = 8'd200;
      if8.divisor   = 8'd7;
      @(posedge clk);
      #1;
      if8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      if8.cancel = 1'b1;
      @(posedge clk);
      #1;
      if8.cancel = 1'b0;
      check("w8_cancel_busy", 64'(if8.busy), 64'd0);
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk);
         #1;
         seen |= if8.out_valid;
      end
      check("w8_cancel_no_result", 64'(seen), 64'd0);
      run8(1'b1, 8'd9, 8'd3, q8, r8, z, lat);
      check("w8_after_cancel_q", 64'(q8), 64'd3);
      check("w8_after_cancel_r", 64'(r8), 64'd0);
      for (int i = 0; i < 30; i++) begin
         s = 1'($urandom);
         a = 32'($urandom_range(0, 255));
         b = (i % 5 == 0) ? 32'd0 : 32'($urandom_range(0, 255));
         run8(s, a[7:0], b[7:0], q8, r8, z, lat);
         model(8, s, 64'(a), 64'(b), mq, mr, mz);
         check($sformatf("rnd8_%0d_q", i), 64'(q8), mq);
         check($sformatf("rnd8_%0d_r", i), 64'(r8), mr);
         check($sformatf("rnd8_%0d_dbz", i), 64'(z), 64'(mz));
         check($sformatf("rnd8_%0d_lat", i), 64'(lat), 64'd8);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
